cache_ctrl_fsm: RTL and testbench

//  Sequences one direct-mapped write-back cache (64 lines x 4 words x 32 bit, 22-bit tag, valid/dirty per line) between a CPU port and a word-wide memory port.

---
 rtl/cache_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Controller for a direct-mapped write-back cache: hit service, dirty-line
// write-back, line refill and CPU stall generation, plus hit/miss counters.
module cache_ctrl_fsm #(
  parameter int ADDR_BITS  = 32,
  parameter int WORD_BITS  = 32,
  parameter int TAG_BITS   = 22,
  parameter int LINE_WORDS = 4,
  parameter int CNT_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_en,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [WORD_BITS-1:0] cpu_din,
  output logic [WORD_BITS-1:0] cpu_dout,
  output logic                 cpu_stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic [WORD_BITS-1:0] cache_din,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic                 cache_invalid,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [WORD_BITS-1:0] cache_dout,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_dout,
  input  logic [WORD_BITS-1:0] mem_din,
  input  logic                 mem_ack,
  output logic [CNT_BITS-1:0]  hit_cnt,
  output logic [CNT_BITS-1:0]  miss_cnt
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = ADDR_BITS - TAG_BITS - WB - 2;
  localparam int LB = ADDR_BITS - WB - 2;
  localparam logic [WB-1:0]       W_LAST = WB'(LINE_WORDS - 1);
  localparam logic [WB-1:0]       W_ONE  = WB'(1);
  localparam logic [CNT_BITS-1:0] C_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_BACKUP, S_FILL} state_t;

  state_t              state, state_nxt;
  logic [WB-1:0]       wcnt, wcnt_nxt;
  logic                prime, prime_nxt;
  logic [LB-1:0]       req_line, req_line_nxt;
  logic [TAG_BITS-1:0] victim_tag, victim_tag_nxt;
  logic                hit_inc, miss_inc;

  logic [TAG_BITS-1:0]  req_tag;
  logic [IB-1:0]        req_idx;
  logic [ADDR_BITS-1:0] backup_addr, fill_addr;

  assign req_tag     = req_line[LB-1 -: TAG_BITS];
  assign req_idx     = req_line[IB-1:0];
  // Victim tag is captured at miss time so the write-back address never
  // depends combinationally on the array's tag output.
  assign backup_addr = {victim_tag, req_idx, wcnt, 2'b00};
  assign fill_addr   = {req_tag, req_idx, wcnt, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      prime      <= 1'b0;
      req_line   <= '0;
      victim_tag <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      prime      <= prime_nxt;
      req_line   <= req_line_nxt;
      victim_tag <= victim_tag_nxt;
      if (hit_inc)  hit_cnt  <= hit_cnt + C_ONE;
      if (miss_inc) miss_cnt <= miss_cnt + C_ONE;
    end
  end

  // Address/strobe paths that depend only on state keep the array and
  // memory handshakes free of combinational loops.
  always_comb begin
    cache_addr = cpu_addr;
    mem_addr   = '0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_BACKUP: begin
        cache_addr = backup_addr;
        mem_addr   = backup_addr;
        mem_cs     = prime;
        mem_we     = 1'b1;
      end
      S_FILL: begin
        cache_addr = fill_addr;
        mem_addr   = fill_addr;
        mem_cs     = 1'b1;
      end
      default: ;
    endcase
  end

  assign cache_din     = (state == S_FILL) ? mem_din : cpu_din;
  assign mem_dout      = cache_dout;
  assign cpu_dout      = cache_dout;
  assign cache_invalid = 1'b0;
  assign cpu_stall     = (state != S_IDLE) | (cpu_en & ~cache_hit);

  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    prime_nxt      = prime;
    req_line_nxt   = req_line;
    victim_tag_nxt = victim_tag;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    cache_store    = 1'b0;
    cache_edit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_en) begin
          if (cache_hit) begin
            hit_inc    = 1'b1;
            cache_edit = cpu_we;
          end else begin
            miss_inc       = 1'b1;
            req_line_nxt   = cpu_addr[ADDR_BITS-1:WB+2];
            victim_tag_nxt = cache_tag;
            wcnt_nxt       = '0;
            prime_nxt      = 1'b0;
            state_nxt      = (cache_valid & cache_dirty) ? S_BACKUP : S_FILL;
          end
        end
      end
      S_BACKUP: begin
        // First cycle of each word only addresses the array; the registered
        // read data is presented to memory on the following cycle.
        if (!prime) begin
          prime_nxt = 1'b1;
        end else if (mem_ack) begin
          prime_nxt = 1'b0;
          wcnt_nxt  = wcnt + W_ONE;
          if (wcnt == W_LAST) begin
            wcnt_nxt  = '0;
            state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          cache_store = 1'b1;
          wcnt_nxt    = wcnt + W_ONE;
          if (wcnt == W_LAST) begin
            wcnt_nxt  = '0;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a behavioural cache array and a
// word-wide memory responder with programmable ack delay.
module tb_cache_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_din = '0;
  logic [31:0] cpu_dout, cache_addr, cache_din, mem_addr, mem_dout, mem_din;
  logic        cpu_stall, cache_store, cache_edit, cache_invalid;
  logic        cache_hit, cache_valid, cache_dirty, mem_cs, mem_we, mem_ack;
  logic [21:0] cache_tag;
  logic [31:0] cache_dout;
  logic [31:0] hit_cnt, miss_cnt;

  cache_ctrl_fsm dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_din(cache_din), .cache_store(cache_store),
    .cache_edit(cache_edit), .cache_invalid(cache_invalid), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
    .cache_dout(cache_dout), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // cache array model
  logic [31:0] data [64][4];
  logic [21:0] tags [64];
  bit          valid [64];
  bit          dirty [64];
  logic [5:0]  idx;
  logic [1:0]  wsel;
  assign idx         = cache_addr[9:4];
  assign wsel        = cache_addr[3:2];
  assign cache_valid = valid[idx];
  assign cache_dirty = dirty[idx];
  assign cache_tag   = tags[idx];
  assign cache_hit   = valid[idx] && (tags[idx] == cache_addr[31:10]);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        valid[i] <= 1'b0;
        dirty[i] <= 1'b0;
      end
    end else if (cache_store) begin
      data[idx][wsel] <= cache_din;
      tags[idx]       <= cache_addr[31:10];
      valid[idx]      <= 1'b1;
      dirty[idx]      <= 1'b0;
    end else if (cache_edit) begin
      data[idx][wsel] <= cache_din;
      dirty[idx]      <= 1'b1;
    end
    cache_dout <= data[idx][wsel];
  end

  // memory responder
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic spur_ack = 1'b0;
  assign mem_ack = (mem_cs && (wait_cnt == ack_delay)) || spur_ack;
  assign mem_din = memword(mem_addr);

  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  int store_cnt = 0;
  always @(posedge clk) begin
    if (!mem_cs || mem_ack) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
    if (mem_cs && mem_ack) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_dout);
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
    if (cache_store) store_cnt <= store_cnt + 1;
  end

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // counts stalled cycles, sampled at negedge; returns at the completing cycle
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (cpu_stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      errs++;
      $error("FAIL stall_timeout: observed %0d expected <100", n);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_en = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n, s0;
  initial begin
    // reset
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk1("rst_mem_cs", mem_cs, 1'b0);
    chk1("rst_stall", cpu_stall, 1'b0);
    chk1("rst_store", cache_store, 1'b0);
    tick;

    // 1: clean read miss
    req(1'b0, 32'h40, 32'h0);
    wait_done(n);
    chk("t1_stall_cycles", 32'(n), 32'd5);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    chk("t1_hit_before", hit_cnt, 32'd0);
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("t1_hit_cnt", hit_cnt, 32'd1);
    chk("t1_dout", cpu_dout, memword(32'h40));
    chk("t1_rd_n", 32'(rd_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_rd_addr", rd_addr_q[i], 32'h40 + 32'(4 * i));
    chk("t1_wr_n", 32'(wr_addr_q.size()), 32'd0);
    chk("t1_stores", 32'(store_cnt), 32'd4);
    tick;

    // 2: write hit
    req(1'b1, 32'h44, 32'hDEADBEEF);
    @(negedge clk);
    chk1("t2_stall", cpu_stall, 1'b0);
    chk1("t2_edit", cache_edit, 1'b1);
    chk("t2_din", cache_din, 32'hDEADBEEF);
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk1("t2_edit_off", cache_edit, 1'b0);
    chk1("t2_dirty", dirty[4], 1'b1);
    chk("t2_hit_cnt", hit_cnt, 32'd2);
    tick;

    // 3: dirty miss, same index new tag
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    req(1'b0, 32'h440, 32'h0);
    wait_done(n);
    chk("t3_stall_cycles", 32'(n), 32'd13);
    chk("t3_miss_cnt", miss_cnt, 32'd2);
    chk("t3_wr_n", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_wr_addr", wr_addr_q[i], 32'h40 + 32'(4 * i));
    chk("t3_wr_d0", wr_data_q[0], memword(32'h40));
    chk("t3_wr_d1", wr_data_q[1], 32'hDEADBEEF);
    chk("t3_wr_d2", wr_data_q[2], memword(32'h48));
    chk("t3_wr_d3", wr_data_q[3], memword(32'h4C));
    chk("t3_rd_n", 32'(rd_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_rd_addr", rd_addr_q[i], 32'h440 + 32'(4 * i));
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("t3_dout", cpu_dout, memword(32'h440));
    chk("t3_hit_cnt", hit_cnt, 32'd3);
    tick;

    // 4: delayed acks on a clean miss
    rd_addr_q.delete();
    ack_delay = 3;
    s0 = store_cnt;
    req(1'b0, 32'h840, 32'h0);
    @(negedge clk);
    chk1("t4_idle_stall", cpu_stall, 1'b1);
    chk1("t4_idle_cs", mem_cs, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk1("t4_cs_held", mem_cs, 1'b1);
      chk("t4_addr_held", mem_addr, 32'h840 + 32'(4 * (k / 4)));
    end
    @(negedge clk);
    chk1("t4_done", cpu_stall, 1'b0);
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("t4_stores", 32'(store_cnt - s0), 32'd4);
    chk("t4_rd_n", 32'(rd_addr_q.size()), 32'd4);
    chk("t4_dout", cpu_dout, memword(32'h840));
    chk("t4_hit_cnt", hit_cnt, 32'd4);
    chk("t4_miss_cnt", miss_cnt, 32'd3);
    ack_delay = 0;
    tick;

    // 5: reset in the middle of a fill
    req(1'b0, 32'hC40, 32'h0);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cpu_en = 1'b0;
    @(negedge clk);
    chk1("t5_mem_cs", mem_cs, 1'b0);
    chk1("t5_store", cache_store, 1'b0);
    chk1("t5_stall", cpu_stall, 1'b0);
    chk("t5_hit_cnt", hit_cnt, 32'd0);
    chk("t5_miss_cnt", miss_cnt, 32'd0);
    tick;
    req(1'b0, 32'hC40, 32'h0);
    wait_done(n);
    chk("t5_remiss_cycles", 32'(n), 32'd5);
    chk("t5_remiss_cnt", miss_cnt, 32'd1);
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("t5_dout", cpu_dout, memword(32'hC40));
    chk("t5_hit_after", hit_cnt, 32'd1);
    tick;

    // 6: cpu_en dropped mid-fill, then a spurious ack while idle
    rd_addr_q.delete();
    s0 = store_cnt;
    req(1'b0, 32'h1040, 32'h0);
    tick; tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk1("t6_stall_no_en", cpu_stall, 1'b1);
    n = 0;
    while (mem_cs === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t6_fill_rest", 32'(n), 32'd3);
    chk1("t6_idle_stall", cpu_stall, 1'b0);
    chk("t6_stores", 32'(store_cnt - s0), 32'd4);
    tick;
    spur_ack = 1'b1;
    @(negedge clk);
    chk1("t6_spur_store", cache_store, 1'b0);
    chk1("t6_spur_cs", mem_cs, 1'b0);
    tick;
    spur_ack = 1'b0;
    @(negedge clk);
    chk("t6_miss_cnt", miss_cnt, 32'd2);
    chk("t6_hit_cnt", hit_cnt, 32'd1);
    chk("t6_stores_after", 32'(store_cnt - s0), 32'd4);
    chk("t6_rd_n", 32'(rd_addr_q.size()), 32'd4);
    tick;
    req(1'b0, 32'h1044, 32'h0);
    @(negedge clk);
    chk1("t6_hit_stall", cpu_stall, 1'b0);
    tick;
    cpu_en = 1'b0;
    @(negedge clk);
    chk("t6_dout", cpu_dout, memword(32'h1044));
    chk("t6_hit_final", hit_cnt, 32'd2);
    chk1("t6_invalid", cache_invalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
